// File: rtl/block_transfer_sequencer_pkg.sv
// Shared definitions for the LDM/STM block transfer sequencer:
// data/select widths, FSM state encoding, the byte stride per beat,
// the four addressing modes, and the helper that derives the first
// (lowest) beat address from the base and the total span.
package block_transfer_sequencer_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREGS  = 16;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned WORD_B = 4;

    // Sequencer states; FIN is the single DONE cycle before returning to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_WB   = 2'd2,
        ST_FIN  = 2'd3
    } seqState_t;

    // Addressing modes, encoded as {P, U}.
    typedef enum logic [1:0] {
        MODE_DA = 2'b00,
        MODE_IA = 2'b01,
        MODE_DB = 2'b10,
        MODE_IB = 2'b11
    } addrMode_t;

    // Lowest beat address for a transfer covering 'span' bytes.
    // Beats always ascend from here, so decrementing modes start below the base.
    function automatic logic [DATA_W-1:0] startAddress(
        input addrMode_t         mode,
        input logic [DATA_W-1:0] base,
        input logic [DATA_W-1:0] span
    );
        logic [DATA_W-1:0] step;
        step = DATA_W'(WORD_B);
        case (mode)
            MODE_IA: startAddress = base;
            MODE_IB: startAddress = base + step;
            MODE_DA: startAddress = base - span + step;
            MODE_DB: startAddress = base - span;
            default: startAddress = base;
        endcase
    endfunction

endpackage

// File: rtl/block_transfer_sequencer_if.sv
// Memory-beat and register-file port bundle driven by the sequencer.
// master = sequencer side, slave = memory/register-file side.
interface block_transfer_sequencer_if;
    import block_transfer_sequencer_pkg::*;

    // Memory interface
    logic              MEM_REQ;
    logic              MEM_WE;
    logic [DATA_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic              MEM_MOC;
    logic [DATA_W-1:0] MEM_RDATA;

    // Register-file port
    logic [SEL_W-1:0]  RF_ADDR;
    logic              RF_RW;
    logic [DATA_W-1:0] RF_WDATA;
    logic [DATA_W-1:0] RF_RDATA;

    modport master (
        output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        output RF_ADDR, RF_RW, RF_WDATA,
        input  MEM_MOC, MEM_RDATA, RF_RDATA
    );

    modport slave (
        input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        input  RF_ADDR, RF_RW, RF_WDATA,
        output MEM_MOC, MEM_RDATA, RF_RDATA
    );

endinterface

// File: rtl/block_transfer_sequencer_lowest_set_bit_16.sv
// Combinational priority encoder: index of the lowest set bit of a
// 16-bit vector plus a valid flag (low when the vector is empty).
module lowest_set_bit_16
    import block_transfer_sequencer_pkg::*;
(
    input  logic [NREGS-1:0] vec,
    output logic [SEL_W-1:0] idx,
    output logic             valid
);

    logic [NREGS-1:0] oneHot;

    // Two's-complement trick isolates the lowest set bit as a one-hot word.
    assign oneHot = vec & (~vec + {{(NREGS-1){1'b0}}, 1'b1});
    assign valid  = |vec;

    // Each index bit is the OR of the one-hot positions whose index has that bit set.
    for (genvar gi = 0; gi < SEL_W; gi++) begin : g_idxBit
        logic [NREGS-1:0] hits;
        for (genvar gj = 0; gj < NREGS; gj++) begin : g_pos
            if (((gj >> gi) & 1) != 0) begin : g_on
                assign hits[gj] = oneHot[gj];
            end else begin : g_off
                assign hits[gj] = 1'b0;
            end
        end
        assign idx[gi] = |hits;
    end

endmodule

// File: rtl/block_transfer_sequencer.sv
// LDM/STM block transfer sequencer. Latches a transfer command, then
// walks the register list lowest-to-highest issuing one memory beat per
// register at ascending word addresses, optionally writes the final base
// back to Rn, and pulses DONE for one cycle.
module block_transfer_sequencer
    import block_transfer_sequencer_pkg::*;
(
    input  logic                     CLK,
    input  logic                     CLR,
    input  logic                     START,
    input  logic                     L,
    input  logic                     U,
    input  logic                     P,
    input  logic                     W,
    input  logic [SEL_W-1:0]         RN,
    input  logic [NREGS-1:0]         REG_LIST,
    input  logic [DATA_W-1:0]        BASE,
    block_transfer_sequencer_if.master bus,
    output logic                     BUSY,
    output logic                     DONE
);

    seqState_t         stateReg, stateNext;
    logic [DATA_W-1:0] addrReg, addrNext;
    logic [DATA_W-1:0] finalBaseReg, finalBaseNext;
    logic [NREGS-1:0]  listReg, listNext;
    logic [SEL_W-1:0]  rnReg, rnNext;
    logic              loadReg, loadNext;
    logic              wbReg, wbNext;

    logic [CNT_W-1:0]  popCount;
    logic [DATA_W-1:0] span;
    logic [DATA_W-1:0] firstAddr;
    logic [SEL_W-1:0]  curIdx;
    logic              curValid;
    logic [NREGS-1:0]  beatBit;
    logic [NREGS-1:0]  remaining;

    logic              memReq;
    logic              memWe;
    logic [DATA_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [SEL_W-1:0]  rfAddr;
    logic              rfRw;
    logic [DATA_W-1:0] rfWdata;
    logic              busyOut;
    logic              doneOut;

    // Register currently being transferred: lowest bit still pending in the latched list.
    lowest_set_bit_16 uLowest (
        .vec   (listReg),
        .idx   (curIdx),
        .valid (curValid)
    );

    assign beatBit   = {{(NREGS-1){1'b0}}, curValid} << curIdx;
    assign remaining = listReg & ~beatBit;

    // Number of registers requested by the incoming command.
    always_comb begin
        popCount = '0;
        for (int i = 0; i < NREGS; i++) begin
            popCount = popCount + CNT_W'(REG_LIST[i]);
        end
    end

    assign span      = DATA_W'(popCount) * DATA_W'(WORD_B);
    assign firstAddr = startAddress(addrMode_t'({P, U}), BASE, span);

    // Next-state, datapath update and output decode.
    always_comb begin
        stateNext     = stateReg;
        addrNext      = addrReg;
        finalBaseNext = finalBaseReg;
        listNext      = listReg;
        rnNext        = rnReg;
        loadNext      = loadReg;
        wbNext        = wbReg;

        memReq   = 1'b0;
        memWe    = 1'b0;
        memAddr  = '0;
        memWdata = '0;
        rfAddr   = '0;
        rfRw     = 1'b0;
        rfWdata  = '0;
        busyOut  = 1'b0;
        doneOut  = 1'b0;

        case (stateReg)
            ST_IDLE: begin
                if (START) begin
                    addrNext      = firstAddr;
                    finalBaseNext = U ? (BASE + span) : (BASE - span);
                    listNext      = REG_LIST;
                    rnNext        = RN;
                    loadNext      = L;
                    // A load that overwrites Rn keeps the loaded value, so no writeback then.
                    wbNext        = W && !(L && REG_LIST[RN]);
                    stateNext     = (popCount == '0) ? ST_FIN : ST_XFER;
                end
            end

            ST_XFER: begin
                busyOut = 1'b1;
                memReq  = 1'b1;
                memWe   = ~loadReg;
                memAddr = addrReg;
                rfAddr  = curIdx;
                if (!loadReg) begin
                    memWdata = bus.RF_RDATA;
                end
                if (bus.MEM_MOC) begin
                    if (loadReg) begin
                        rfRw    = 1'b1;
                        rfWdata = bus.MEM_RDATA;
                    end
                    listNext = remaining;
                    addrNext = addrReg + DATA_W'(WORD_B);
                    if (remaining == '0) begin
                        stateNext = wbReg ? ST_WB : ST_FIN;
                    end
                end
            end

            ST_WB: begin
                busyOut   = 1'b1;
                rfRw      = 1'b1;
                rfAddr    = rnReg;
                rfWdata   = finalBaseReg;
                stateNext = ST_FIN;
            end

            ST_FIN: begin
                doneOut   = 1'b1;
                stateNext = ST_IDLE;
            end

            default: stateNext = ST_IDLE;
        endcase
    end

    // State and latched-command registers; CLR abandons any transfer in progress.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            stateReg     <= ST_IDLE;
            addrReg      <= '0;
            finalBaseReg <= '0;
            listReg      <= '0;
            rnReg        <= '0;
            loadReg      <= 1'b0;
            wbReg        <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            addrReg      <= addrNext;
            finalBaseReg <= finalBaseNext;
            listReg      <= listNext;
            rnReg        <= rnNext;
            loadReg      <= loadNext;
            wbReg        <= wbNext;
        end
    end

    assign bus.MEM_REQ   = memReq;
    assign bus.MEM_WE    = memWe;
    assign bus.MEM_ADDR  = memAddr;
    assign bus.MEM_WDATA = memWdata;
    assign bus.RF_ADDR   = rfAddr;
    assign bus.RF_RW     = rfRw;
    assign bus.RF_WDATA  = rfWdata;
    assign BUSY          = busyOut;
    assign DONE          = doneOut;

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Testbench for block_transfer_sequencer: directed scenarios followed by
// randomized transfers, each checked cycle by cycle against a reference
// model that derives beat addresses, register order, writeback and DONE
// timing directly from the transfer rules.
module tb_block_transfer_sequencer;

    logic        clk = 1'b0;
    logic        clrIn;
    logic        startIn;
    logic        lIn, uIn, pIn, wIn;
    logic [3:0]  rnIn;
    logic [15:0] regListIn;
    logic [31:0] baseIn;
    logic        busy, done;

    logic [31:0] rfModel [16];

    int testsRun  = 0;
    int failCount = 0;
    int txnCount  = 0;

    block_transfer_sequencer_if ifc ();

    assign ifc.RF_RDATA = rfModel[ifc.RF_ADDR];

    block_transfer_sequencer dut (
        .CLK      (clk),
        .CLR      (clrIn),
        .START    (startIn),
        .L        (lIn),
        .U        (uIn),
        .P        (pIn),
        .W        (wIn),
        .RN       (rnIn),
        .REG_LIST (regListIn),
        .BASE     (baseIn),
        .bus      (ifc),
        .BUSY     (busy),
        .DONE     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Command inputs must be latched at START, so garble them while busy.
    task automatic scrambleInputs();
        startIn   = 1'($urandom);
        lIn       = 1'($urandom);
        uIn       = 1'($urandom);
        pIn       = 1'($urandom);
        wIn       = 1'($urandom);
        rnIn      = 4'($urandom);
        regListIn = 16'($urandom);
        baseIn    = $urandom;
    endtask

    task automatic checkQuiet(input string tag);
        check({tag, ".req"},  32'(ifc.MEM_REQ), 32'd0);
        check({tag, ".rfrw"}, 32'(ifc.RF_RW),   32'd0);
        check({tag, ".busy"}, 32'(busy),        32'd0);
        check({tag, ".done"}, 32'(done),        32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkQuiet(tag);
        check({tag, ".we"},      32'(ifc.MEM_WE),   32'd0);
        check({tag, ".addr"},    ifc.MEM_ADDR,      32'd0);
        check({tag, ".rfaddr"},  32'(ifc.RF_ADDR),  32'd0);
        check({tag, ".rfwdata"}, ifc.RF_WDATA,      32'd0);
    endtask

    // One complete transfer. clrBeat >= 0 asserts CLR in the first cycle of that beat.
    task automatic runTxn(input string name, input logic cL, input logic cU, input logic cP,
                          input logic cW, input logic [3:0] cRn, input logic [15:0] cList,
                          input logic [31:0] cBase, input int waitMin, input int waitMax,
                          input int clrBeat);
        int          regQ[$];
        int          n;
        logic [31:0] lowAddr;
        logic [31:0] finalBase;
        logic        doWb;
        logic        moc;
        logic [31:0] rdata;
        int          waitCycles;

        for (int i = 0; i < 16; i++) begin
            if (cList[i]) regQ.push_back(i);
        end
        n = regQ.size();
        if (cU) lowAddr = cBase + (cP ? 32'd4 : 32'd0);
        else    lowAddr = cBase - 32'(4 * n) + (cP ? 32'd0 : 32'd4);
        finalBase = cU ? cBase + 32'(4 * n) : cBase - 32'(4 * n);
        doWb = cW && (n != 0) && !(cL && cList[cRn]);
        for (int i = 0; i < 16; i++) rfModel[i] = $urandom;

        txnCount++;
        $display("[TB] txn %0d %s: %s %s%s list=%04h base=%08h W=%0b RN=%0d n=%0d wb=%0b final=%08h",
                 txnCount, name, cL ? "LDM" : "STM", cU ? "I" : "D", cP ? "B" : "A",
                 cList, cBase, cW, cRn, n, doWb, finalBase);

        // START cycle: still idle.
        @(negedge clk);
        startIn = 1'b1; lIn = cL; uIn = cU; pIn = cP; wIn = cW;
        rnIn = cRn; regListIn = cList; baseIn = cBase;
        ifc.MEM_MOC = 1'($urandom);
        #1;
        checkQuiet({name, ".start"});

        for (int k = 0; k < n; k++) begin
            waitCycles = $urandom_range(waitMax, waitMin);
            for (int c = 0; c <= waitCycles; c++) begin
                @(negedge clk);
                scrambleInputs();
                moc = (c == waitCycles);
                if (clrBeat == k) begin
                    moc   = 1'b0;
                    clrIn = 1'b1;
                end
                rdata = $urandom;
                ifc.MEM_MOC   = moc;
                ifc.MEM_RDATA = rdata;
                #1;
                check($sformatf("%s.b%0d.req", name, k),    32'(ifc.MEM_REQ), 32'd1);
                check($sformatf("%s.b%0d.busy", name, k),   32'(busy),        32'd1);
                check($sformatf("%s.b%0d.done", name, k),   32'(done),        32'd0);
                check($sformatf("%s.b%0d.we", name, k),     32'(ifc.MEM_WE),  32'(!cL));
                check($sformatf("%s.b%0d.addr", name, k),   ifc.MEM_ADDR,     lowAddr + 32'(4 * k));
                check($sformatf("%s.b%0d.rfaddr", name, k), 32'(ifc.RF_ADDR), 32'(regQ[k]));
                check($sformatf("%s.b%0d.rfrw", name, k),   32'(ifc.RF_RW),   32'(cL && moc));
                if (cL && moc)
                    check($sformatf("%s.b%0d.rfwdata", name, k), ifc.RF_WDATA, rdata);
                if (!cL)
                    check($sformatf("%s.b%0d.wdata", name, k), ifc.MEM_WDATA, rfModel[regQ[k]]);
                if (clrBeat == k) begin
                    @(negedge clk);
                    clrIn = 1'b0; startIn = 1'b0; ifc.MEM_MOC = 1'b0;
                    #1;
                    checkResetValues({name, ".afterclr"});
                    @(negedge clk);
                    #1;
                    checkQuiet({name, ".afterclr2"});
                    return;
                end
            end
        end

        if (doWb) begin
            @(negedge clk);
            scrambleInputs();
            ifc.MEM_MOC = 1'($urandom);
            #1;
            check({name, ".wb.rfrw"},    32'(ifc.RF_RW),   32'd1);
            check({name, ".wb.rfaddr"},  32'(ifc.RF_ADDR), 32'(cRn));
            check({name, ".wb.rfwdata"}, ifc.RF_WDATA,     finalBase);
            check({name, ".wb.req"},     32'(ifc.MEM_REQ), 32'd0);
            check({name, ".wb.busy"},    32'(busy),        32'd1);
            check({name, ".wb.done"},    32'(done),        32'd0);
        end

        // FIN cycle: START and MEM_MOC here must be ignored.
        @(negedge clk);
        scrambleInputs();
        ifc.MEM_MOC = 1'($urandom);
        #1;
        check({name, ".fin.done"}, 32'(done),        32'd1);
        check({name, ".fin.busy"}, 32'(busy),        32'd0);
        check({name, ".fin.req"},  32'(ifc.MEM_REQ), 32'd0);
        check({name, ".fin.rfrw"}, 32'(ifc.RF_RW),   32'd0);

        // Back in IDLE with no new START.
        @(negedge clk);
        startIn = 1'b0;
        ifc.MEM_MOC = 1'($urandom);
        #1;
        checkQuiet({name, ".idle"});
    endtask

    // Hard stop in case the run never reaches its summary.
    initial begin
        #1000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rl;
        clrIn = 1'b1; startIn = 1'b0; lIn = 1'b0; uIn = 1'b0; pIn = 1'b0; wIn = 1'b0;
        rnIn = '0; regListIn = '0; baseIn = '0;
        ifc.MEM_MOC = 1'b0; ifc.MEM_RDATA = '0;
        for (int i = 0; i < 16; i++) rfModel[i] = '0;

        @(negedge clk);
        @(negedge clk);
        #1;
        checkResetValues("reset");
        @(negedge clk);
        clrIn = 1'b0;

        runTxn("ldm_ia_wb",   1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 16'h0005, 32'h0000_0100, 0, 0, -1);
        runTxn("stm_db_wb",   1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 16'h8002, 32'h0000_0200, 0, 0, -1);
        runTxn("ldm_ib_wait", 1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0001, 32'h0000_0100, 3, 3, -1);
        runTxn("empty_list",  1'b1, 1'b1, 1'b0, 1'b1, 4'd5,  16'h0000, 32'h0000_0300, 0, 0, -1);
        runTxn("ldm_rn_in",   1'b1, 1'b1, 1'b0, 1'b1, 4'd2,  16'h0004, 32'h0000_0400, 0, 1, -1);
        runTxn("stm_clr",     1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 16'h00F0, 32'h0000_0500, 1, 2, 1);
        runTxn("after_clr",   1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 16'h00F0, 32'h0000_0500, 0, 1, -1);
        runTxn("db_wrap",     1'b0, 1'b0, 1'b1, 1'b1, 4'd1,  16'h0007, 32'h0000_0004, 0, 0, -1);
        runTxn("ia_wrap",     1'b1, 1'b1, 1'b1, 1'b1, 4'd9,  16'hFFFF, 32'hFFFF_FFF0, 0, 1, -1);
        runTxn("da_stm",      1'b0, 1'b0, 1'b0, 1'b0, 4'd3,  16'h4210, 32'h1000_0000, 0, 2, -1);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(3, 0))
                0:       rl = 16'h0000;
                1:       rl = 16'($urandom);
                default: rl = 16'($urandom) & 16'($urandom) & 16'($urandom);
            endcase
            runTxn($sformatf("rand%0d", t), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 4'($urandom), rl, $urandom, 0, 3, -1);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
